// File: rtl/rf_spi_arbiter.sv
// rf_spi_arbiter: shares the RF transceiver SPI command port between requesters.
// Grants are round-robin, with an optional lock for bursts. One command is issued,
// completion is awaited under a watchdog, and the response is routed to the winner.
module rf_spi_arbiter #(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_lock,
    input  logic [2*NREQ-1:0]      req_mode,
    input  logic [ADDR_W*NREQ-1:0] req_addr,
    input  logic [DATA_W*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   rf_c_en,
    output logic [1:0]             rf_mode,
    output logic [ADDR_W-1:0]      rf_addr,
    output logic [DATA_W-1:0]      rf_data,
    input  logic                   rf_ready,
    input  logic [DATA_W-1:0]      rf_rdata,
    output logic                   busy,
    output logic [1:0]             grant_id
);
    localparam int              WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
    localparam logic [1:0]      LAST   = 2'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [1:0]        ptr, lock_owner, winner, cand;
    logic              lock_active, lock_lat, found, lock_drop, wait_done;
    logic [WD_W-1:0]   wd;
    logic [3:0]        valid4, ready4, rspv4;
    logic [1:0]        sel_mode;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_lock;

    // Pad request vector to 4 lanes so 2-bit indices are always in range
    always_comb valid4 = 4'(req_valid);

    // WAIT ends on completion, or on watchdog expiry; completion wins a tie
    always_comb wait_done = rf_ready || (wd == WD_MAX);

    // Winner selection: lock owner while a lock is held, else first valid from ptr
    always_comb begin
        found     = 1'b0;
        winner    = '0;
        lock_drop = 1'b0;
        cand      = '0;
        if (lock_active) begin
            if (valid4[lock_owner]) begin
                found  = 1'b1;
                winner = lock_owner;
            end else begin
                lock_drop = 1'b1;
            end
        end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                cand = 2'((32'(ptr) + k) % NREQ);
                if (!found && valid4[cand]) begin
                    found  = 1'b1;
                    winner = cand;
                end
            end
        end
    end

    // Request field mux for the selected winner
    always_comb begin
        sel_mode  = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_lock  = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (winner == 2'(k)) begin
                sel_mode  = req_mode[2*k +: 2];
                sel_addr  = req_addr[ADDR_W*k +: ADDR_W];
                sel_wdata = req_wdata[DATA_W*k +: DATA_W];
                sel_lock  = req_lock[k];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (wait_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode; req_ready is combinational, so it is also held low during reset
    always_comb begin
        ready4 = '0;
        rspv4  = '0;
        if (state == IDLE && found && !rst) ready4[winner] = 1'b1;
        if (state == RESP) rspv4[grant_id] = 1'b1;
        req_ready = ready4[NREQ-1:0];
        rsp_valid = rspv4[NREQ-1:0];
        rf_c_en   = (state == ISSUE);
        busy      = (state != IDLE);
    end

    // Datapath: grant latching, pointer/lock tracking, watchdog and response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            grant_id    <= '0;
            lock_owner  <= '0;
            lock_active <= 1'b0;
            lock_lat    <= 1'b0;
            wd          <= '0;
            rf_mode     <= '0;
            rf_addr     <= '0;
            rf_data     <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (lock_drop) lock_active <= 1'b0;
                    if (found) begin
                        grant_id <= winner;
                        ptr      <= (winner == LAST) ? 2'd0 : winner + 2'd1;
                        rf_mode  <= sel_mode;
                        rf_addr  <= sel_addr;
                        rf_data  <= sel_wdata;
                        lock_lat <= sel_lock;
                    end
                end
                ISSUE: wd <= '0;
                WAIT: begin
                    if (wait_done) begin
                        rsp_rdata   <= (rf_ready && !rf_mode[0]) ? rf_rdata : '0;
                        rsp_err     <= !rf_ready;
                        // Latched lock bit of this access decides whether the lock persists
                        lock_active <= lock_lat;
                        if (lock_lat) lock_owner <= grant_id;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rf_spi_arbiter.sv
// Testbench for rf_spi_arbiter: directed steps with a request list, expected grant
// order queue and a response scoreboard filled at grant time.
module tb_rf_spi_arbiter;
    localparam int NREQ    = 3;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid, req_lock, req_ready, rsp_valid;
    logic [2*NREQ-1:0]      req_mode;
    logic [ADDR_W*NREQ-1:0] req_addr;
    logic [DATA_W*NREQ-1:0] req_wdata;
    logic [DATA_W-1:0]      rsp_rdata, rf_data, rf_rdata;
    logic                   rsp_err, rf_c_en, rf_ready, busy;
    logic [1:0]             rf_mode, grant_id;
    logic [ADDR_W-1:0]      rf_addr;

    always #5 clk = ~clk;

    rf_spi_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_lock(req_lock), .req_mode(req_mode),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rf_c_en(rf_c_en), .rf_mode(rf_mode), .rf_addr(rf_addr), .rf_data(rf_data),
        .rf_ready(rf_ready), .rf_rdata(rf_rdata), .busy(busy), .grant_id(grant_id)
    );

    typedef struct {
        int         id;
        logic [1:0] mode;
        logic [9:0] addr;
        logic [7:0] wdata;
        logic       lock;
        int         delay;   // cycles from rf_c_en to rf_ready; 0 = never
        logic [7:0] rv;      // value presented on rf_rdata
    } req_t;

    typedef struct {
        int         id;
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    req_t pend[$];
    int   exp_grant[$];
    rsp_t rsp_q[$];
    req_t cur;
    bit   in_txn;
    int   cycle, ready_cyc, cen_cyc, rdy_at;
    int   total, bad, rsp_seen, snap;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(string tag);
        total++;
        bad++;
        $error("FAIL %s observed=event expected=none", tag);
    endtask

    task automatic push_req(int id, logic [1:0] mode, logic [9:0] addr, logic [7:0] wdata,
                            logic lock, int delay, logic [7:0] rv);
        req_t r;
        r.id = id; r.mode = mode; r.addr = addr; r.wdata = wdata;
        r.lock = lock; r.delay = delay; r.rv = rv;
        pend.push_back(r);
    endtask

    // Present the head request of each requester and the SPI-side completion
    task automatic drive();
        req_valid = '0; req_lock = '0; req_mode = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = 0; j < pend.size(); j++) begin
                if (pend[j].id == i) begin
                    req_valid[i]               = 1'b1;
                    req_lock[i]                = pend[j].lock;
                    req_mode[2*i +: 2]         = pend[j].mode;
                    req_addr[ADDR_W*i +: ADDR_W] = pend[j].addr;
                    req_wdata[DATA_W*i +: DATA_W] = pend[j].wdata;
                    break;
                end
            end
        end
        rf_ready = (cycle + 1 == rdy_at);
        rf_rdata = rf_ready ? cur.rv : 8'hEE;
    endtask

    task automatic observe();
        int   w;
        rsp_t e;
        if (req_ready != '0) begin
            w = 0;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) w = i;
            check("ready_onehot", 64'($countones(req_ready)), 64'(1));
            check("busy_in_idle", 64'(busy), 64'(0));
            if (exp_grant.size() == 0) fail_now("grant_unexpected");
            else check("grant_order", 64'(w), 64'(exp_grant.pop_front()));
            for (int j = 0; j < pend.size(); j++) begin
                if (pend[j].id == w) begin
                    cur = pend[j];
                    pend.delete(j);
                    break;
                end
            end
            in_txn    = 1'b1;
            ready_cyc = cycle;
            rdy_at    = -1;
            e.id      = w;
            e.err     = (cur.delay == 0 || cur.delay > TIMEOUT + 1);
            e.rdata   = (e.err || cur.mode[0]) ? 8'h00 : cur.rv;
            rsp_q.push_back(e);
        end
        if (rf_c_en) begin
            if (!in_txn) fail_now("cen_unexpected");
            else begin
                check("cen_latency", 64'(cycle - ready_cyc), 64'(1));
                check("rf_mode", 64'(rf_mode), 64'(cur.mode));
                check("rf_addr", 64'(rf_addr), 64'(cur.addr));
                check("rf_data", 64'(rf_data), 64'(cur.wdata));
                check("grant_id", 64'(grant_id), 64'(cur.id));
                cen_cyc = cycle;
                if (cur.delay > 0) rdy_at = cycle + cur.delay;
            end
        end
        if (rsp_valid != '0) begin
            rsp_seen++;
            if (rsp_q.size() == 0) fail_now("rsp_unexpected");
            else begin
                e = rsp_q.pop_front();
                check("rsp_valid_vec", 64'(rsp_valid), 64'(1) << e.id);
                check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
                check("rsp_latency", 64'(cycle), 64'(e.err ? cen_cyc + TIMEOUT + 2 : rdy_at + 1));
                in_txn = 1'b0;
            end
        end
    endtask

    // One clock: sample at the falling edge, drive just after the rising edge
    task automatic cyc();
        @(negedge clk);
        cycle++;
        if (!rst) observe();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_until_idle(int max);
        bit done;
        done = 1'b0;
        for (int n = 0; n < max && !done; n++) begin
            cyc();
            done = (pend.size() == 0 && rsp_q.size() == 0 && !in_txn);
        end
        if (!done) fail_now("drain_timeout");
    endtask

    initial begin
        rst = 1'b1;
        cycle = 0; rdy_at = -1; in_txn = 1'b0; total = 0; bad = 0; rsp_seen = 0;
        ready_cyc = 0; cen_cyc = 0;
        cur = '{id: 0, mode: 2'b00, addr: 10'h0, wdata: 8'h0, lock: 1'b0, delay: 0, rv: 8'h0};
        drive();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_a", 64'({req_ready, rsp_valid, rsp_rdata, rsp_err, rf_c_en}), 64'(0));
        check("rst_out_b", 64'({rf_mode, rf_addr, rf_data, busy, grant_id}), 64'(0));
        rst = 1'b0;
        cyc();

        // Short write; read data on the bus must not leak into the response
        push_req(0, 2'b01, 10'h018, 8'hA5, 1'b0, 12, 8'h77);
        exp_grant.push_back(0);
        drive();
        run_until_idle(60);
        check("rf_addr_hold", 64'(rf_addr), 64'(10'h018));
        check("rf_data_hold", 64'(rf_data), 64'(8'hA5));

        // Long read with the fastest completion
        push_req(1, 2'b10, 10'h300, 8'h00, 1'b0, 1, 8'h3C);
        exp_grant.push_back(1);
        drive();
        run_until_idle(60);

        // Completion in the last WAIT cycle beats the watchdog
        push_req(2, 2'b00, 10'h055, 8'h00, 1'b0, TIMEOUT + 1, 8'h5A);
        exp_grant.push_back(2);
        drive();
        run_until_idle(60);

        // Fairness: all three held valid across six transactions
        for (int r = 0; r < 2; r++) begin
            push_req(0, 2'b00, 10'h010 + 10'(r), 8'h00, 1'b0, 1 + r, 8'h11 + 8'(r));
            push_req(1, 2'b01, 10'h020 + 10'(r), 8'h22 + 8'(r), 1'b0, 2, 8'h44);
            push_req(2, 2'b10, 10'h3F0 + 10'(r), 8'h00, 1'b0, 3, 8'h33 + 8'(r));
        end
        for (int r = 0; r < 6; r++) exp_grant.push_back(r % 3);
        drive();
        run_until_idle(200);

        // Lock burst: requester 2 holds the port while 0 and 1 wait
        for (int r = 0; r < 3; r++) push_req(2, 2'b00, 10'h0A0 + 10'(r), 8'h00, 1'b1, 2, 8'hB0 + 8'(r));
        push_req(2, 2'b01, 10'h0A3, 8'hC3, 1'b0, 2, 8'h00);
        exp_grant.push_back(2);
        drive();
        for (int n = 0; n < 20 && exp_grant.size() != 0; n++) cyc();
        if (exp_grant.size() != 0) fail_now("lock_first_grant_timeout");
        push_req(0, 2'b01, 10'h111, 8'h5C, 1'b0, 1, 8'h00);
        push_req(1, 2'b00, 10'h122, 8'h00, 1'b0, 1, 8'hD7);
        exp_grant.push_back(2); exp_grant.push_back(2); exp_grant.push_back(2);
        exp_grant.push_back(0); exp_grant.push_back(1);
        drive();
        run_until_idle(200);

        // Watchdog: no completion at all
        push_req(0, 2'b00, 10'h200, 8'h00, 1'b0, 0, 8'h00);
        exp_grant.push_back(0);
        drive();
        run_until_idle(100);
        check("idle_after_timeout", 64'(busy), 64'(0));

        // Watchdog with a late completion landing in the response cycle
        push_req(0, 2'b00, 10'h201, 8'h00, 1'b0, TIMEOUT + 2, 8'h9E);
        exp_grant.push_back(0);
        drive();
        run_until_idle(100);

        // Reset during WAIT abandons the transaction
        push_req(1, 2'b01, 10'h2AA, 8'h3E, 1'b0, 0, 8'h00);
        exp_grant.push_back(1);
        drive();
        repeat (3) cyc();
        check("busy_in_wait", 64'(busy), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("rst_mid_a", 64'({req_ready, rsp_valid, rsp_rdata, rsp_err, rf_c_en}), 64'(0));
        check("rst_mid_b", 64'({rf_mode, rf_addr, rf_data, busy, grant_id}), 64'(0));
        rsp_q.delete(); exp_grant.delete(); in_txn = 1'b0; rdy_at = -1;
        repeat (2) cyc();
        rst = 1'b0;
        rdy_at = cycle + 2;
        cur.rv = 8'h99;
        snap = rsp_seen;
        repeat (6) cyc();
        check("stray_ready_no_rsp", 64'(rsp_seen - snap), 64'(0));

        // Pointer restarts at 0 after reset
        push_req(2, 2'b00, 10'h3A2, 8'h00, 1'b0, 1, 8'h62);
        push_req(1, 2'b00, 10'h3A1, 8'h00, 1'b0, 1, 8'h61);
        push_req(0, 2'b00, 10'h3A0, 8'h00, 1'b0, 1, 8'h60);
        exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(2);
        drive();
        run_until_idle(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
